// File: rtl/mul_seq.sv
// Iterative shift-and-add unsigned multiplier; result is the low WIDTH bits of a*b, ovf flags nonzero high bits.
// Latency: WIDTH cycles from the accepting edge to the one-cycle done pulse; one result per WIDTH+1 cycles.
// Backpressure: none; start is honoured only in IDLE or DONE, and is ignored without queueing while busy.
// Ports: clk, rst_n (async active-low); start/a/b request a multiply;
//        busy is high while iterating; done pulses when result/ovf update (drives accumulator CE).
module mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] next_prod;
  logic               accept;
  logic               last_step;

  // Partial product for this RUN step; the sum of WIDTH shifted copies of a
  // never exceeds 2*WIDTH bits, so no carry out is needed.
  always_comb begin
    next_prod = prod;
    if (mplier[0]) begin
      next_prod = prod + mcand;
    end
  end

  // A new operation may start from IDLE or straight out of DONE (back-to-back).
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_step = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          prod   <= next_prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            state  <= S_DONE;
            result <= next_prod[WIDTH-1:0];
            ovf    <= |next_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          // IDLE and DONE behave identically apart from DONE always leaving.
          if (accept) begin
            state  <= S_RUN;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode straight from the state register: no input-to-output path.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq against an arithmetic reference (a*b split into low half and overflow).
// A load-on-CE register models the downstream accumulator fed by result/done.
module tb_mul_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  logic [W-1:0] acc_q;

  int n_cmp = 0;
  int n_bad = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream accumulator register: IN=result, CE=done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (done) acc_q <= result;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: full product, then split into the registered low half and overflow flag.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return W'(p % (1 << W));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return (p >= (1 << W));
  endfunction

  // Called just after a falling edge. Launches one operation, waits (bounded) for done,
  // and checks latency, busy width, result, ovf, done width and the accumulator.
  // With noise set, start/a/b are scrambled while busy; those must be ignored.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
    int  cyc;
    int  busy_cnt;
    bit  seen;
    a = av; b = bv; start = 1'b1;
    @(posedge clk);             // accepting edge k
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;               // negedges observed after edge k
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc <= 3 * W) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'(seen), 32'd1);
    end else begin
      check("latency", 32'(cyc - 1), 32'(W));
      check("busy_cycles", 32'(busy_cnt), 32'(W));
      check("busy_at_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(ref_res(av, bv)));
      check("ovf", 32'(ovf), 32'(ref_ovf(av, bv)));
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("acc_out", 32'(acc_q), 32'(ref_res(av, bv)));
    end
  endtask

  initial begin
    int gap;
    bit seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operands, including zero and full-scale corners.
    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd5, 4'd5, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0, 4'd9, 1'b0);
    run_op(4'd7, 4'd0, 1'b0);
    // Mid-run start pulses with different operands must not disturb the result.
    run_op(4'd6, 4'd7, 1'b1);

    // Back-to-back with start held high: second op taken on the DONE-cycle edge.
    a = 4'd2; b = 4'd6; start = 1'b1;
    @(posedge clk);
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("b2b_first_done", 32'(seen), 32'd1);
    check("b2b_first_res", 32'(result), 32'd12);
    a = 4'd3; b = 4'd3;
    seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      gap++;
      if (i == 0) check("b2b_no_idle", 32'(busy), 32'd1);
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_gap", 32'(gap), 32'(W + 1));
    check("b2b_second_res", 32'(result), 32'd9);
    @(negedge clk);

    // Asynchronous reset in the middle of 5*3: outputs clear with no clock edge.
    a = 4'd5; b = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    run_op(4'd2, 4'd7, 1'b0);

    // Result and ovf hold after completion; done stays low so the accumulator holds.
    run_op(4'd5, 4'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", 32'(result), 32'd9);
      check("hold_ovf", 32'(ovf), 32'd1);
      check("hold_done", 32'(done), 32'd0);
      check("hold_acc", 32'(acc_q), 32'd9);
    end

    // Randomized operands, half of them with mid-run noise on the inputs.
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative shift-and-add unsigned multiplier that sits directly upstream of the accumulator register. It accepts two WIDTH-bit operands on a START strobe and computes the product over WIDTH clock cycles. It then presents the low WIDTH bits on RESULT with a one-cycle DONE pulse, which drives the accumulator's CE input directly. The high half of the product is reduced to an overflow flag.

## Interface
- WIDTH, 4: operand, result and accumulator width; legal range 2..16.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a multiply; sampled on the rising edge in IDLE or DONE only.
- A  in  WIDTH  multiplicand, unsigned; captured on the accepting edge.
- B  in  WIDTH  multiplier, unsigned; captured on the accepting edge.
- BUSY  out  1  high while in RUN.
- DONE  out  1  high for exactly one cycle when RESULT/OVF update; feeds accumulator CE.
- RESULT  out  WIDTH  low WIDTH bits of A*B, registered.
- OVF  out  1  high if the upper WIDTH bits of the 2*WIDTH product are nonzero, registered.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - prod: 2*WIDTH bits.
  - cnt: enough bits for 0..WIDTH-1.
- IDLE with START=1: mcand={0,A}, mplier=B, prod=0, cnt=0, go to RUN. IDLE with START=0: stay.
- RUN, every edge:
  - if mplier[0], prod = prod + mcand (2*WIDTH-bit add, no carry out possible);
  - mcand shifts left by 1; mplier shifts right by 1; cnt increments.
  - When cnt==WIDTH-1 on this edge, go to DONE. On the same edge, load RESULT=next_prod[WIDTH-1:0] and OVF=|next_prod[2*WIDTH-1:WIDTH].
- DONE: lasts one cycle. START=1 accepts a new operation exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- START while in RUN is ignored and not queued. A and B changes during RUN have no effect.
- RESULT and OVF hold their last values until the next completion. They are not cleared on START.
- No early termination: latency is fixed regardless of operand values, including zero operands.
- Outputs are decoded from the state register: BUSY = (state==RUN), DONE = (state==DONE). No combinational path from inputs to outputs.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE; BUSY=0, DONE=0, RESULT=0, OVF=0.
  - Internal datapath registers are cleared to 0.
  - The in-flight operation is discarded and no DONE is produced.
  - Release of RST_N takes effect at the next rising edge; START is honoured on that edge.

## Timing
- START accepted at edge k. BUSY=1 from after edge k through edge k+WIDTH.
- RUN steps occur on edges k+1 .. k+WIDTH. RESULT/OVF are valid and DONE=1 after edge k+WIDTH.
- The accumulator captures RESULT at edge k+WIDTH+1 (CE=DONE).
- Latency from accepting edge to DONE high: WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles with START held high.
- Reset values: BUSY=0, DONE=0, RESULT=0, OVF=0.

## Test plan
All scenarios use WIDTH=4, with the accumulator instance connected (IN=RESULT, CE=DONE).

- A=3, B=5, START pulse at edge k -> BUSY high for 4 cycles; DONE after edge k+4 with RESULT=15, OVF=0; accumulator OUT=15 after edge k+5.
- A=5, B=5 -> RESULT=9 (25 mod 16), OVF=1. A=15, B=15 -> RESULT=1 (225=0xE1), OVF=1.
- A=0, B=9 and A=7, B=0 -> each RESULT=0, OVF=0, still exactly 4 cycles of BUSY; DONE pulse width exactly 1 cycle.
- START held high, operands changed each DONE (2*6, then 3*3) -> second op accepted on the DONE-cycle edge; results 12 then 9, DONE pulses 5 cycles apart, no IDLE cycle. START pulsed mid-RUN with different A/B -> ignored, result unchanged.
- RST_N low asynchronously during RUN of 5*3 (between edges) -> BUSY, DONE, RESULT and OVF go to 0 immediately with no clock edge; no DONE pulse ever appears for that op. After release, 2*7 completes normally with RESULT=14.
- After a completion of 5*5 with no further START -> RESULT=9 and OVF=1 stay stable for 10+ cycles; DONE stays 0, so the accumulator holds.
